// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state type, default MISR constants and the
// signature step function, also used by the pattern-generator side.
package bist_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h100B;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;
    localparam int unsigned MISR_MAX_W   = 64;

    // One MISR step for any width up to MISR_MAX_W; callers zero-extend and truncate.
    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           sig_w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (sig_w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << sig_w) - MISR_MAX_W'(1));
        fb   = |((sig >> (sig_w - 1)) & MISR_MAX_W'(1));
        return ((sig << 1) ^ (fb ? poly : '0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: synchronous seed load, or one
// compaction step per enabled cycle.
module misr_reg
    import bist_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [SIG_W-1:0] i_seed,
    input  logic             i_en,
    input  logic [SIG_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig,
    output logic [SIG_W-1:0] o_next
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_next;

    assign w_next = SIG_W'(misr_next(MISR_MAX_W'(r_sig), MISR_MAX_W'(i_data),
                                     MISR_MAX_W'(POLY), SIG_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_load) begin
            r_sig <= i_seed;
        end else if (i_en) begin
            r_sig <= w_next;
        end
    end

    assign o_sig  = r_sig;
    assign o_next = w_next;

endmodule

// File: rtl/ripple_adder_misr_checker.sv
// Response-side BIST checker: compacts {co, sum} adder results into a MISR and
// compares the signature with GOLDEN after PATTERNS responses.
module ripple_adder_misr_checker
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      SIG_W    = 16,
    parameter int unsigned      PATTERNS = 16,
    parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED     = SIG_W'(DEFAULT_SEED),
    parameter logic [SIG_W-1:0] GOLDEN   = SIG_W'(16'h8000)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] sum,
    input  logic             co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      resp_count
);

    localparam logic [15:0] LAST_COUNT = 16'(PATTERNS - 1);

    bist_state_e      r_state;
    logic [15:0]      r_count;
    logic             r_pass;
    logic [SIG_W-1:0] w_data;
    logic [SIG_W-1:0] w_next;
    logic             w_load;
    logic             w_absorb;

    // Requires WIDTH+1 <= SIG_W so the response fits the signature unchanged.
    always_comb begin
        w_data             = '0;
        w_data[WIDTH:0]    = {co, sum};
    end

    assign w_load   = start && (r_state != RUN);
    assign w_absorb = resp_valid && (r_state == RUN);

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_seed (SEED),
        .i_en   (w_absorb),
        .i_data (w_data),
        .o_sig  (signature),
        .o_next (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_count <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        r_count <= r_count + 16'd1;
                        // Verdict taken from the signature this same edge writes.
                        if (r_count == LAST_COUNT) begin
                            r_state <= DONE;
                            r_pass  <= (w_next == GOLDEN);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign pass       = r_pass;
    assign resp_count = r_count;

endmodule

// File: tb/tb_ripple_adder_misr_checker.sv
// Scoreboard bench for ripple_adder_misr_checker: a polynomial-arithmetic model
// queues expected results, a monitor checks every observable state change.
module tb_ripple_adder_misr_checker;

    localparam logic [15:0] POLY   = 16'h100B;
    localparam logic [15:0] SEED   = 16'h0000;
    localparam logic [15:0] GOLDEN = 16'h8000;
    localparam int          PATS   = 16;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        resp_valid = 1'b0;
    logic [3:0]  sum = '0;
    logic        co = 1'b0;
    logic        busy, done, pass;
    logic [15:0] signature, resp_count;

    logic        start1 = 1'b0;
    logic        valid1 = 1'b0;
    logic [3:0]  sum1 = '0;
    logic        co1 = 1'b0;
    logic        busy1, done1, pass1;
    logic [15:0] sig1, cnt1;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        q[$];

    logic        m_run = 1'b0, m_done = 1'b0, m_pass = 1'b0;
    logic [15:0] m_sig = '0, m_cnt = '0;

    ripple_adder_misr_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .resp_valid (resp_valid),
        .sum        (sum),
        .co         (co),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .resp_count (resp_count)
    );

    ripple_adder_misr_checker #(
        .PATTERNS (1),
        .GOLDEN   (16'h001F)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .resp_valid (valid1),
        .sum        (sum1),
        .co         (co1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .signature  (sig1),
        .resp_count (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signature times x modulo the polynomial, plus the response word.
    function automatic logic [15:0] ref_next(input logic [15:0] s, input logic [4:0] d);
        logic [16:0] t;
        t = {s, 1'b0};
        if (t[16]) t = t ^ {1'b1, POLY};
        return t[15:0] ^ {11'b0, d};
    endfunction

    task automatic step(input logic st, input logic v, input logic [4:0] d);
        exp_t e;
        start = st;
        resp_valid = v;
        {co, sum} = d;
        @(posedge clk);
        if (m_run && v) begin
            m_sig = ref_next(m_sig, d);
            m_cnt = m_cnt + 16'd1;
            if (m_cnt == 16'(PATS)) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_pass = (m_sig == GOLDEN);
            end
            e = '{sig: m_sig, cnt: m_cnt, busy: m_run, done: m_done, pass: m_pass};
            q.push_back(e);
        end else if (!m_run && st) begin
            m_run = 1'b1; m_done = 1'b0; m_pass = 1'b0; m_sig = SEED; m_cnt = '0;
            e = '{sig: SEED, cnt: 16'd0, busy: 1'b1, done: 1'b0, pass: 1'b0};
            q.push_back(e);
        end
        #1;
        start = 1'b0;
        resp_valid = 1'b0;
    endtask

    // Monitor: every change of busy/done/count is one scoreboard entry.
    logic [17:0] last_obs = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_obs = '0;
        end else if ({busy, done, resp_count} != last_obs) begin
            last_obs = {busy, done, resp_count};
            if (q.size() == 0) begin
                check("unexpected_output", 32'(resp_count), 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("sb_signature", 32'(signature), 32'(e.sig));
                check("sb_count", 32'(resp_count), 32'(e.cnt));
                check("sb_busy", 32'(busy), 32'(e.busy));
                check("sb_done", 32'(done), 32'(e.done));
                check("sb_pass", 32'(pass), 32'(e.pass));
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_sig"}, 32'(signature), 32'd0);
        check({tag, "_count"}, 32'(resp_count), 32'd0);
    endtask

    task automatic single_bit_run(input string tag);
        step(1'b1, 1'b0, 5'h00);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_seed"}, 32'(signature), 32'(SEED));
        for (int i = 0; i < PATS; i++) begin
            step(1'b0, 1'b1, (i == 0) ? 5'h01 : 5'h00);
            if (i == PATS - 2) check({tag, "_not_done_early"}, 32'(done), 32'd0);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd1);
        check({tag, "_sig"}, 32'(signature), 32'h8000);
        check({tag, "_count"}, 32'(resp_count), 32'd16);
    endtask

    initial begin
        #2;
        check_idle("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-run
        step(1'b1, 1'b0, 5'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 5'(i + 3));
        rst_n = 1'b0;
        #1 check_idle("rst_async");
        @(posedge clk);
        #1 check_idle("rst_hold");
        q.delete();
        m_run = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_sig = '0; m_cnt = '0;
        rst_n = 1'b1;

        single_bit_run("single");

        // Feedback path, ending with a failing signature
        step(1'b1, 1'b0, 5'h00);
        for (int i = 1; i <= PATS; i++) begin
            step(1'b0, 1'b1, (i == 1) ? 5'h10 : 5'h00);
            if (i == 12) check("fb_sig12", 32'(signature), 32'h8000);
            if (i == 13) check("fb_sig13", 32'(signature), 32'h100B);
        end
        check("fb_sig_final", 32'(signature), 32'h8058);
        check("fb_done", 32'(done), 32'd1);
        check("fb_pass", 32'(pass), 32'd0);

        // Restart from DONE, then a passing rerun
        step(1'b1, 1'b0, 5'h00);
        check("restart_done_fall", 32'(done), 32'd0);
        check("restart_sig_seed", 32'(signature), 32'(SEED));
        check("restart_busy", 32'(busy), 32'd1);
        for (int i = 0; i < PATS; i++) step(1'b0, 1'b1, (i == 0) ? 5'h01 : 5'h00);
        check("rerun_pass", 32'(pass), 32'd1);

        // Gaps, a stray start mid-RUN and a start on the final response
        step(1'b1, 1'b0, 5'h00);
        check("gap_restart_pass_fall", 32'(pass), 32'd0);
        for (int k = 0; k < 2 * PATS - 1; k++) begin
            step((k == 7) || (k == 2 * PATS - 2), (k % 2) == 0, (k == 0) ? 5'h01 : 5'h00);
            if (k == 2 * PATS - 3) check("gap_not_done_early", 32'(done), 32'd0);
        end
        check("gap_done", 32'(done), 32'd1);
        check("gap_sig", 32'(signature), 32'h8000);
        check("gap_pass", 32'(pass), 32'd1);
        step(1'b0, 1'b1, 5'h1F);
        check("done_ignores_valid", 32'(signature), 32'h8000);

        // Randomised runs against the model
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            step(1'b1, 1'b0, 5'h00);
            while (m_run && n < 400) begin
                step(($urandom % 8) == 0, ($urandom % 4) != 0, 5'($urandom));
                n++;
            end
            check("rand_done", 32'(done), 32'd1);
        end

        // PATTERNS=1 instance
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        check("p1_busy", 32'(busy1), 32'd1);
        valid1 = 1'b1;
        {co1, sum1} = 5'h1F;
        @(posedge clk);
        #1;
        check("p1_sig", 32'(sig1), 32'h001F);
        check("p1_done", 32'(done1), 32'd1);
        check("p1_pass", 32'(pass1), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("p1_sig_hold", 32'(sig1), 32'h001F);
        check("p1_count_hold", 32'(cnt1), 32'd1);
        valid1 = 1'b0;

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ripple_adder_misr_checker.md
# ripple_adder_misr_checker

Response-side BIST block for the ripple adder: compacts each `{co, sum}` result produced by the adder under test into a multiple-input signature register (MISR) and compares the final signature with a golden value. It sits at the output end of the adder; a pattern source drives the adder inputs and `resp_valid`. The checker reports pass/fail once a fixed number of responses has been absorbed.

## Interface
- `WIDTH`, 4: adder sum width; requires `WIDTH+1 <= SIG_W`.
- `SIG_W`, 16: signature width.
- `PATTERNS`, 16: responses per test; range 1..65535.
- `POLY`, 16'h100B: feedback taps (x^16+x^12+x^3+x+1), excluding the x^SIG_W term.
- `SEED`, 0: signature value loaded on start.
- `GOLDEN`, 16'h8000: expected final signature.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a test from IDLE or DONE.
- `resp_valid`  in  1  `sum`/`co` hold a response to compact this cycle.
- `sum`  in  WIDTH  adder sum output.
- `co`  in  1  adder carry-out.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  final signature == GOLDEN; valid only while `done`.
- `signature`  out  SIG_W  current MISR contents.
- `resp_count`  out  16  responses absorbed in the current test.

## Operation
- Reset values: state IDLE, all outputs 0 (`signature` = 0, not SEED).
- States and transitions:
  - IDLE to RUN on `start`. Same edge: `signature` <= SEED, `resp_count` <= 0.
  - RUN to DONE on the edge absorbing response number PATTERNS.
  - DONE to RUN on `start`, with the same reload as from IDLE.
  - No other exits. `start` in RUN is ignored.
- MISR update, applied only in RUN with `resp_valid`:
  - `signature` <= `(signature << 1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zext({co, sum})`.
  - `resp_count` increments on the same edge.
- `resp_valid` outside RUN is ignored. `resp_valid` low in RUN holds all state; gaps are allowed.
- `pass` is registered on the RUN-to-DONE edge from the updated signature value. It holds, together with `signature` and `resp_count`, until the next start or reset.
- Reset mid-test returns immediately to IDLE and clears everything. There is no resume.
- `resp_count` width is fixed at 16 bits and never wraps, because PATTERNS ≤ 65535.

## Timing
- Compaction latency is 1 cycle: a response on edge N is visible in `signature` after edge N.
- `busy` rises the cycle after `start`.
- `done` and `pass` rise on the same edge as the final absorbed response. `busy` falls on that edge.
- Minimum test length is PATTERNS+1 cycles from the `start` pulse with `resp_valid` held high.
- `start` coincident with the final response in RUN: the response is absorbed and `start` is ignored.
- `start` while in DONE: the test restarts on that edge; `done` and `pass` fall on that edge.

## Structure
- Shared package `bist_pkg`:
  - state enum `{IDLE, RUN, DONE}`
  - default POLY/SEED constants
  - a `misr_next(sig, data, poly)` function, reused by a future LFSR pattern generator
- One natural sub-module, `misr_reg`:
  - parameterised SIG_W/POLY register with `load`, `seed`, `en`, `data` inputs
  - FSM, counter and compare stay in the top.

## Test plan
All scenarios use default parameters unless stated.
- **Reset:** `rst_n`=0 mid-run. Expect `busy`/`done`/`pass`=0, `signature`=0, `resp_count`=0 while low. A subsequent `start` works normally.
- **Single-bit, no feedback:** `start`, then 16 valid responses: `{co,sum}`=5'h01 first, then 5'h00 ×15. Expect `signature`=16'h8000, `resp_count`=16, `done`=1, `pass`=1.
- **Feedback path:** first response 5'h10 (`co`=1), then 5'h00 ×15.
  - Expect intermediate `signature`=16'h8000 after the 12th response and 16'h100B after the 13th.
  - Expect final 16'h8058 and `pass`=0.
- **Gaps and stray inputs:** same stimulus as single-bit with `resp_valid` low on alternate cycles and `start` pulsed mid-RUN. Expect identical result (16'h8000, `pass`=1), completing 15 cycles later.
- **Restart from DONE:** after a failing run, pulse `start`.
  - Expect `done`/`pass` to fall on that edge and `signature`=SEED.
  - Rerunning the single-bit stimulus gives `pass`=1.
- **PATTERNS=1:** one response 5'h1F. Expect `signature`=16'h001F and `done` on the same edge. `resp_valid` held high afterwards leaves `signature` unchanged.
